// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - WIDTH-bit universal shift register with edge select and full-shift pulse
module universal_shift_reg #(
    parameter int                 WIDTH       = 8,
    parameter bit                 NEG_EDGE    = 1'b1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    parameter bit                 ROTATE      = 1'b0
) (
    input  logic             clock,
    input  logic             resetp,
    input  logic             en,
    input  logic             sclr,
    input  logic [1:0]       mode,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_lsb,
    output logic             ser_out_msb,
    output logic             shift_done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             clk_act;
    logic             fill_msb, fill_lsb;

    // Falling-edge operation is an inverted clock into rising-edge flops.
    assign clk_act = NEG_EDGE ? ~clock : clock;

    // With ROTATE the serial inputs are never looked at, so an X there cannot leak in.
    assign fill_msb = ROTATE ? q_q[0]       : ser_in_msb;
    assign fill_lsb = ROTATE ? q_q[WIDTH-1] : ser_in_lsb;

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (sclr) begin
            q_d   = RESET_VALUE;
            cnt_d = '0;
        end else if (en) begin
            case (mode)
                MODE_HOLD: ;
                MODE_RIGHT: q_d = {fill_msb, q_q[WIDTH-1:1]};
                MODE_LEFT:  q_d = {q_q[WIDTH-2:0], fill_lsb};
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                default: ;
            endcase
            if (mode == MODE_RIGHT || mode == MODE_LEFT) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_act or posedge resetp) begin
        if (resetp) begin
            q_q    <= RESET_VALUE;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q           = q_q;
    assign ser_out_lsb = q_q[0];
    assign ser_out_msb = q_q[WIDTH-1];
    assign shift_done  = done_q;

endmodule
